// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write arbiter slice.
// Holds the arbiter state encoding and a width helper.
package fifo_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arbState_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: scans upward from startIdx with wrap,
// so the entry just below startIdx is considered last.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [IDX_W-1:0]   startIdx,
    output logic               found,
    output logic [IDX_W-1:0]   winIdx
);

    always_comb begin
        int cand;
        found  = 1'b0;
        winIdx = '0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(startIdx) + k) % NUM_REQ;
            if (!found && reqValid[IDX_W'(cand)]) begin
                found  = 1'b1;
                winIdx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo_sync write port
// among NUM_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    input  logic                          fifoFullIn,
    output logic                          fifoWrEnOut,
    output logic [DATA_WIDTH-1:0]         fifoWrDataOut,
    output logic [NUM_REQ-1:0]            grantOut,
    output logic [clog2(NUM_REQ)-1:0]     grantIdxOut
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BURST_MAX) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    arbState_t          state, stateNext;
    logic [NUM_REQ-1:0] grant, grantNext;
    logic [IDX_W-1:0]   grantIdx, grantIdxNext;
    logic [CNT_W-1:0]   burstCnt, burstCntNext;
    logic [IDX_W-1:0]   startIdx, pickIdx;
    logic               pickFound;
    logic               xfer;
    logic               granteeValid;
    logic               doRelease;

    // Search starts just past the last grantee, so it is seen last.
    assign startIdx = (grantIdx == IDX_LAST) ? '0 : grantIdx + 1'b1;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) picker (
        .reqValid (reqValidIn),
        .startIdx (startIdx),
        .found    (pickFound),
        .winIdx   (pickIdx)
    );

    // Ready is gated by reset so a reset edge never carries a write.
    assign reqReadyOut = (rstIn && state == ARB_BUSY && !fifoFullIn)
                       ? grant : '0;
    assign xfer          = |(reqValidIn & reqReadyOut);
    assign fifoWrEnOut   = xfer;
    assign granteeValid  = reqValidIn[grantIdx];
    assign fifoWrDataOut = reqDataIn[grantIdx*DATA_WIDTH +: DATA_WIDTH];
    assign grantOut      = grant;
    assign grantIdxOut   = grantIdx;

    always_comb begin
        stateNext    = state;
        grantNext    = grant;
        grantIdxNext = grantIdx;
        burstCntNext = burstCnt;
        doRelease    = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (pickFound) begin
                    stateNext    = ARB_BUSY;
                    grantNext    = NUM_REQ'(1) << pickIdx;
                    grantIdxNext = pickIdx;
                    burstCntNext = '0;
                end
            end
            ARB_BUSY: begin
                doRelease = !granteeValid
                          || (xfer && burstCnt == CNT_LAST);
                if (doRelease) begin
                    if (pickFound) begin
                        grantNext    = NUM_REQ'(1) << pickIdx;
                        grantIdxNext = pickIdx;
                        burstCntNext = '0;
                    end else begin
                        stateNext = ARB_IDLE;
                        grantNext = '0;
                    end
                end else if (xfer) begin
                    burstCntNext = burstCnt + 1'b1;
                end
            end
            default: stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            grantIdx <= IDX_LAST;
            burstCnt <= '0;
        end else begin
            state    <= stateNext;
            grant    <= grantNext;
            grantIdx <= grantIdxNext;
            burstCnt <= burstCntNext;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based producers, FIFO and a
// rule-level arbitration model, directed scenarios then random traffic.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int B     = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic           full;
    logic           wrEn;
    logic [W-1:0]   wrData;
    logic [N-1:0]   grant;
    logic [1:0]     gIdx;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .BURST_MAX  (B)
    ) dut (
        .clkIn         (clk),
        .rstIn         (rstn),
        .reqValidIn    (valid),
        .reqDataIn     (data),
        .reqReadyOut   (ready),
        .fifoFullIn    (full),
        .fifoWrEnOut   (wrEn),
        .fifoWrDataOut (wrData),
        .grantOut      (grant),
        .grantIdxOut   (gIdx)
    );

    logic [W-1:0] prodQ [N][$];
    logic [W-1:0] fifoQ[$];
    logic [W-1:0] rdQ[$];
    logic [W-1:0] expQ[$];
    logic [W-1:0] expC[$];
    logic         rdEn;

    bit mBusy;
    int mLast;
    int mCnt;
    int nChecks = 0;
    int nPass   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            valid[i] = prodQ[i].size() != 0;
            data[i*W +: W] = valid[i] ? prodQ[i][0] : '0;
        end
        full = fifoQ.size() >= DEPTH;
    endtask

    task automatic step();
        logic [N-1:0] one;
        logic [N-1:0] expReady;
        logic [N-1:0] expGrant;
        logic [W-1:0] wd;
        bit xfer, doWr, doRd, rel;
        int p, xIdx;
        one = 1;
        @(negedge clk);
        xfer = mBusy && rstn && !full && valid[mLast];
        expReady = xfer || (mBusy && rstn && !full) ? one << mLast : '0;
        check("ready", ready, expReady);
        check("wrEn", wrEn, xfer);
        if (xfer) check("wrData", wrData, prodQ[mLast][0]);
        if (full) check("writeWhileFull", wrEn, 0);
        doWr = wrEn;
        wd   = wrData;
        doRd = rdEn && fifoQ.size() > 0;
        xIdx = mLast;
        if (xfer) expQ.push_back(prodQ[mLast][0]);
        if (!rstn) begin
            mBusy = 0; mLast = N - 1; mCnt = 0;
        end else if (!mBusy) begin
            p = pick(valid, mLast);
            if (p >= 0) begin mBusy = 1; mLast = p; mCnt = 0; end
        end else begin
            rel = !valid[mLast];
            if (xfer) begin
                mCnt++;
                if (mCnt == B) rel = 1;
            end
            if (rel) begin
                p = pick(valid, mLast);
                if (p >= 0) begin mLast = p; mCnt = 0; end
                else mBusy = 0;
            end
        end
        @(posedge clk);
        #1;
        expGrant = mBusy ? one << mLast : '0;
        check("grant", grant, expGrant);
        check("grantIdx", gIdx, mLast);
        if (doRd) rdQ.push_back(fifoQ.pop_front());
        if (doWr) fifoQ.push_back(wd);
        if (xfer) void'(prodQ[xIdx].pop_front());
        drive();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic resetPulse();
        rstn = 1'b0;
        run(2);
        rstn = 1'b1;
    endtask

    task automatic drainCheck(string tag);
        while (fifoQ.size() > 0) rdQ.push_back(fifoQ.pop_front());
        check({tag, "_count"}, rdQ.size(), expQ.size());
        for (int i = 0; i < rdQ.size() && i < expQ.size(); i++)
            check({tag, "_order"}, rdQ[i], expQ[i]);
    endtask

    task automatic constCheck(string tag);
        check({tag, "_constCount"}, rdQ.size(), expC.size());
        for (int i = 0; i < rdQ.size() && i < expC.size(); i++)
            check({tag, "_const"}, rdQ[i], expC[i]);
        rdQ.delete();
        expQ.delete();
        expC.delete();
    endtask

    initial begin
        rstn = 1'b0; rdEn = 1'b0; valid = '0; data = '0; full = 1'b0;
        mBusy = 0; mLast = N - 1; mCnt = 0;
        run(2);
        check("rstGrant", grant, 0);
        check("rstIdx", gIdx, N - 1);
        rstn = 1'b1;

        // 1: single producer, re-win without bubble
        for (int k = 0; k < 6; k++) prodQ[0].push_back(8'hA0 + W'(k));
        drive();
        run(12);
        drainCheck("s1");
        for (int k = 0; k < 6; k++) expC.push_back(8'hA0 + W'(k));
        constCheck("s1");

        // 2: all producers valid, grants rotate 0..3
        resetPulse();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) prodQ[i].push_back(W'(i * 16 + k));
        drive();
        rdEn = 1'b1;
        run(24);
        drainCheck("s2");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) expC.push_back(W'(i * 16 + k));
        constCheck("s2");

        // 3: backpressure from a full FIFO mid-burst
        rdEn = 1'b0;
        prodQ[0].push_back(8'h50);
        prodQ[0].push_back(8'h51);
        for (int k = 0; k < 12; k++) prodQ[1].push_back(8'h40 + W'(k));
        drive();
        run(14);
        check("s3_fullCount", fifoQ.size(), DEPTH);
        rdEn = 1'b1;
        step();
        rdEn = 1'b0;
        run(3);
        check("s3_oneWrite", fifoQ.size(), DEPTH);
        check("s3_oneRead", rdQ.size(), 1);
        rdEn = 1'b1;
        run(20);
        drainCheck("s3");
        expC.push_back(8'h50);
        expC.push_back(8'h51);
        for (int k = 0; k < 12; k++) expC.push_back(8'h40 + W'(k));
        constCheck("s3");

        // 4: grantee drops valid after two words
        resetPulse();
        prodQ[2].push_back(8'h60);
        prodQ[2].push_back(8'h61);
        for (int k = 0; k < 4; k++) prodQ[3].push_back(8'h70 + W'(k));
        drive();
        run(12);
        drainCheck("s4");
        expC = {8'h60, 8'h61, 8'h70, 8'h71, 8'h72, 8'h73};
        constCheck("s4");

        // 5: reset during a burst
        resetPulse();
        for (int k = 0; k < 8; k++) prodQ[1].push_back(8'h80 + W'(k));
        drive();
        run(3);
        for (int k = 0; k < 4; k++) prodQ[0].push_back(8'h90 + W'(k));
        drive();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("s5_firstAfterRst", grant, 4'b0001);
        run(16);
        drainCheck("s5");
        rdQ.delete(); expQ.delete();

        // 6: producers 1 and 3 only, with wrap
        resetPulse();
        for (int k = 0; k < 8; k++) begin
            prodQ[1].push_back(8'hB0 + W'(k));
            prodQ[3].push_back(8'hC0 + W'(k));
        end
        drive();
        for (int c = 0; c < 24; c++) begin
            step();
            check("s6_idleNoGrant", grant & 4'b0101, 0);
        end
        drainCheck("s6");
        rdQ.delete(); expQ.delete();

        // random traffic with occasional reset and backpressure
        for (int c = 0; c < 800; c++) begin
            int unsigned r;
            r = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) == 0 && prodQ[r].size() < 6)
                prodQ[r].push_back(W'($urandom));
            rdEn = $urandom_range(0, 9) < 4;
            rstn = $urandom_range(0, 99) != 0;
            drive();
            step();
        end
        rstn = 1'b1;
        rdEn = 1'b1;
        drive();
        run(60);
        drainCheck("rand");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
